// File: rtl/vx_mem_arb.sv
// vx_mem_arb: N-to-1 memory request arbiter with a tag-based response router.
//
// Several per-core request channels share one memory port. The winning
// channel's index is appended to the LSBs of the outgoing tag. The memory
// returns that tag with the response, and the index in it selects the
// channel that gets the response. No lookup table is needed.
//
// Ports
//   clk, reset              clock, asynchronous active-low reset
//   req_*_in / req_ready_in per-channel request channels (flattened buses)
//   mem_req_*               shared outgoing request
//   mem_rsp_*               shared incoming response
//   rsp_*_out / rsp_ready_out per-channel response channels (flattened buses)
//
// ARB_MODE     0 = round-robin, 1 = fixed priority (lowest index wins)
// BUFFERED_REQ 1 = 2-entry skid buffer on the request output, 0 = comb + grant lock
// BUFFERED_RSP 1 = 2-entry skid buffer per response channel, 0 = comb
module vx_mem_arb #(
  parameter  int NUM_REQS      = 4,
  parameter  int DATA_WIDTH    = 512,
  parameter  int ADDR_WIDTH    = 32,
  parameter  int SIZE_WIDTH    = 3,
  parameter  int TAG_IN_WIDTH  = 8,
  parameter  int ARB_MODE      = 0,
  parameter  int BUFFERED_REQ  = 1,
  parameter  int BUFFERED_RSP  = 1,
  localparam int LOG_N         = (NUM_REQS > 1) ? $clog2(NUM_REQS) : 0,
  localparam int TAG_OUT_WIDTH = TAG_IN_WIDTH + LOG_N,
  localparam int BYTEEN_WIDTH  = DATA_WIDTH / 8
) (
  input  logic                               clk,
  input  logic                               reset,

  input  logic [NUM_REQS-1:0]                req_valid_in,
  input  logic [NUM_REQS-1:0]                req_rw_in,
  input  logic [NUM_REQS*BYTEEN_WIDTH-1:0]   req_byteen_in,
  input  logic [NUM_REQS*SIZE_WIDTH-1:0]     req_size_in,
  input  logic [NUM_REQS*ADDR_WIDTH-1:0]     req_addr_in,
  input  logic [NUM_REQS*DATA_WIDTH-1:0]     req_data_in,
  input  logic [NUM_REQS*TAG_IN_WIDTH-1:0]   req_tag_in,
  output logic [NUM_REQS-1:0]                req_ready_in,

  output logic                               mem_req_valid,
  output logic                               mem_req_rw,
  output logic [BYTEEN_WIDTH-1:0]            mem_req_byteen,
  output logic [SIZE_WIDTH-1:0]              mem_req_size,
  output logic [ADDR_WIDTH-1:0]              mem_req_addr,
  output logic [DATA_WIDTH-1:0]              mem_req_data,
  output logic [TAG_OUT_WIDTH-1:0]           mem_req_tag,
  input  logic                               mem_req_ready,

  input  logic                               mem_rsp_valid,
  input  logic [DATA_WIDTH-1:0]              mem_rsp_data,
  input  logic [TAG_OUT_WIDTH-1:0]           mem_rsp_tag,
  output logic                               mem_rsp_ready,

  output logic [NUM_REQS-1:0]                rsp_valid_out,
  output logic [NUM_REQS*DATA_WIDTH-1:0]     rsp_data_out,
  output logic [NUM_REQS*TAG_IN_WIDTH-1:0]   rsp_tag_out,
  input  logic [NUM_REQS-1:0]                rsp_ready_out
);

  localparam int IDX_W = (LOG_N > 0) ? LOG_N : 1;
  localparam int REQ_W = 1 + BYTEEN_WIDTH + SIZE_WIDTH + ADDR_WIDTH + DATA_WIDTH + TAG_OUT_WIDTH;
  localparam int RSP_W = DATA_WIDTH + TAG_IN_WIDTH;

  // ---------------------------------------------------------------------------
  // Per-channel views of the flattened request buses
  // ---------------------------------------------------------------------------
  logic [BYTEEN_WIDTH-1:0] byteen_arr [NUM_REQS];
  logic [SIZE_WIDTH-1:0]   size_arr   [NUM_REQS];
  logic [ADDR_WIDTH-1:0]   addr_arr   [NUM_REQS];
  logic [DATA_WIDTH-1:0]   data_arr   [NUM_REQS];
  logic [TAG_IN_WIDTH-1:0] tag_arr    [NUM_REQS];

  for (genvar i = 0; i < NUM_REQS; i++) begin : g_unpack
    assign byteen_arr[i] = req_byteen_in[i*BYTEEN_WIDTH +: BYTEEN_WIDTH];
    assign size_arr[i]   = req_size_in[i*SIZE_WIDTH +: SIZE_WIDTH];
    assign addr_arr[i]   = req_addr_in[i*ADDR_WIDTH +: ADDR_WIDTH];
    assign data_arr[i]   = req_data_in[i*DATA_WIDTH +: DATA_WIDTH];
    assign tag_arr[i]    = req_tag_in[i*TAG_IN_WIDTH +: TAG_IN_WIDTH];
  end

  // ---------------------------------------------------------------------------
  // Arbitration
  // ---------------------------------------------------------------------------
  logic [IDX_W-1:0]         ptr_q, ptr_d;
  logic                     lock_q, lock_d;
  logic [IDX_W-1:0]         lock_idx_q, lock_idx_d;
  logic [IDX_W-1:0]         arb_idx, win_idx, cand;
  logic                     arb_found, win_valid;
  logic                     can_accept, in_hs;
  logic [TAG_OUT_WIDTH-1:0] sel_tag;
  logic [REQ_W-1:0]         sel_pkt, req_out_pkt;
  int                       c;

  // Scan starts at the RR pointer (or at 0 in fixed mode) and wraps.
  always_comb begin
    arb_idx   = '0;
    arb_found = 1'b0;
    cand      = '0;
    c         = 0;
    for (int k = 0; k < NUM_REQS; k++) begin
      c = (ARB_MODE == 0) ? int'(ptr_q) + k : k;
      if (c >= NUM_REQS) c = c - NUM_REQS;
      cand = IDX_W'(c);
      if (!arb_found && req_valid_in[cand]) begin
        arb_found = 1'b1;
        arb_idx   = cand;
      end
    end
  end

  // A stalled unbuffered request keeps its grant so its payload stays stable.
  always_comb begin
    win_idx   = arb_idx;
    win_valid = arb_found;
    if (BUFFERED_REQ == 0 && lock_q) begin
      win_idx   = lock_idx_q;
      win_valid = req_valid_in[lock_idx_q];
    end
  end

  assign in_hs = win_valid & can_accept & reset;

  // Readies are gated with reset, so no transfer can look complete while reset is held.
  always_comb begin
    req_ready_in = '0;
    if (in_hs) req_ready_in[win_idx] = 1'b1;
  end

  always_comb begin
    ptr_d      = ptr_q;
    lock_d     = 1'b0;
    lock_idx_d = lock_idx_q;
    if (ARB_MODE == 0 && NUM_REQS > 1 && in_hs)
      ptr_d = (win_idx == IDX_W'(NUM_REQS - 1)) ? '0 : win_idx + IDX_W'(1);
    if (BUFFERED_REQ == 0) begin
      lock_d     = win_valid & ~mem_req_ready;
      lock_idx_d = win_idx;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ptr_q      <= '0;
      lock_q     <= 1'b0;
      lock_idx_q <= '0;
    end else begin
      ptr_q      <= ptr_d;
      lock_q     <= lock_d;
      lock_idx_q <= lock_idx_d;
    end
  end

  if (LOG_N > 0) begin : g_tag_idx
    assign sel_tag = {tag_arr[win_idx], win_idx};
  end else begin : g_tag_pass
    assign sel_tag = tag_arr[win_idx];
  end

  assign sel_pkt = {req_rw_in[win_idx], byteen_arr[win_idx], size_arr[win_idx],
                    addr_arr[win_idx], data_arr[win_idx], sel_tag};

  // ---------------------------------------------------------------------------
  // Request output path
  // ---------------------------------------------------------------------------
  if (BUFFERED_REQ != 0) begin : g_req_buf
    logic [REQ_W-1:0] rb0_q, rb0_d, rb1_q, rb1_d;
    logic [1:0]       rcnt_q, rcnt_d;
    logic             rpop;

    assign can_accept    = (rcnt_q != 2'd2);
    assign rpop          = (rcnt_q != 2'd0) & mem_req_ready;
    assign mem_req_valid = (rcnt_q != 2'd0);
    assign req_out_pkt   = rb0_q;

    // rb0 is always the head; a push with a pop on a full buffer shifts rb1 down.
    always_comb begin
      rb0_d  = rb0_q;
      rb1_d  = rb1_q;
      rcnt_d = rcnt_q;
      case ({in_hs, rpop})
        2'b10: begin
          if (rcnt_q == 2'd0) rb0_d = sel_pkt;
          else                rb1_d = sel_pkt;
          rcnt_d = rcnt_q + 2'd1;
        end
        2'b01: begin
          rb0_d  = rb1_q;
          rcnt_d = rcnt_q - 2'd1;
        end
        2'b11: begin
          if (rcnt_q == 2'd1) rb0_d = sel_pkt;
          else begin
            rb0_d = rb1_q;
            rb1_d = sel_pkt;
          end
        end
        default: ;
      endcase
    end

    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        rcnt_q <= 2'd0;
        rb0_q  <= '0;
        rb1_q  <= '0;
      end else begin
        rcnt_q <= rcnt_d;
        rb0_q  <= rb0_d;
        rb1_q  <= rb1_d;
      end
    end
  end else begin : g_req_comb
    assign can_accept    = mem_req_ready;
    assign mem_req_valid = win_valid & reset;
    assign req_out_pkt   = sel_pkt;
  end

  assign {mem_req_rw, mem_req_byteen, mem_req_size,
          mem_req_addr, mem_req_data, mem_req_tag} = req_out_pkt;

  // ---------------------------------------------------------------------------
  // Response routing
  // ---------------------------------------------------------------------------
  logic [IDX_W-1:0]        rsp_idx;
  logic [TAG_IN_WIDTH-1:0] rsp_tag_strip;
  logic                    idx_ok;
  logic [NUM_REQS-1:0]     dst_ready;

  if (LOG_N > 0) begin : g_rsp_idx
    assign rsp_idx       = mem_rsp_tag[LOG_N-1:0];
    assign rsp_tag_strip = mem_rsp_tag[TAG_OUT_WIDTH-1:LOG_N];
  end else begin : g_rsp_single
    assign rsp_idx       = '0;
    assign rsp_tag_strip = mem_rsp_tag;
  end

  // Only a non-power-of-two channel count can carry an index with no channel.
  if (NUM_REQS == (1 << LOG_N)) begin : g_idx_full
    assign idx_ok = 1'b1;
  end else begin : g_idx_part
    assign idx_ok = (rsp_idx < IDX_W'(NUM_REQS));
    assert property (@(posedge clk) disable iff (!reset) mem_rsp_valid |-> idx_ok);
  end

  // An out-of-range response is accepted and dropped.
  assign mem_rsp_ready = reset & (idx_ok ? dst_ready[rsp_idx] : 1'b1);

  for (genvar i = 0; i < NUM_REQS; i++) begin : g_rsp
    logic hit;
    assign hit = mem_rsp_valid & idx_ok & (rsp_idx == IDX_W'(i));

    if (BUFFERED_RSP != 0) begin : g_buf
      logic [RSP_W-1:0] sb0_q, sb0_d, sb1_q, sb1_d;
      logic [1:0]       scnt_q, scnt_d;
      logic             spush, spop;

      assign dst_ready[i]   = (scnt_q != 2'd2);
      assign spush          = hit & dst_ready[i] & reset;
      assign spop           = (scnt_q != 2'd0) & rsp_ready_out[i];
      assign rsp_valid_out[i] = (scnt_q != 2'd0);
      assign {rsp_data_out[i*DATA_WIDTH +: DATA_WIDTH],
              rsp_tag_out[i*TAG_IN_WIDTH +: TAG_IN_WIDTH]} = sb0_q;

      always_comb begin
        sb0_d  = sb0_q;
        sb1_d  = sb1_q;
        scnt_d = scnt_q;
        case ({spush, spop})
          2'b10: begin
            if (scnt_q == 2'd0) sb0_d = {mem_rsp_data, rsp_tag_strip};
            else                sb1_d = {mem_rsp_data, rsp_tag_strip};
            scnt_d = scnt_q + 2'd1;
          end
          2'b01: begin
            sb0_d  = sb1_q;
            scnt_d = scnt_q - 2'd1;
          end
          2'b11: begin
            if (scnt_q == 2'd1) sb0_d = {mem_rsp_data, rsp_tag_strip};
            else begin
              sb0_d = sb1_q;
              sb1_d = {mem_rsp_data, rsp_tag_strip};
            end
          end
          default: ;
        endcase
      end

      always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
          scnt_q <= 2'd0;
          sb0_q  <= '0;
          sb1_q  <= '0;
        end else begin
          scnt_q <= scnt_d;
          sb0_q  <= sb0_d;
          sb1_q  <= sb1_d;
        end
      end
    end else begin : g_comb
      assign dst_ready[i]     = rsp_ready_out[i];
      assign rsp_valid_out[i] = hit & reset;
      assign rsp_data_out[i*DATA_WIDTH +: DATA_WIDTH]       = mem_rsp_data;
      assign rsp_tag_out[i*TAG_IN_WIDTH +: TAG_IN_WIDTH]    = rsp_tag_strip;
    end
  end

endmodule

// File: tb/tb_vx_mem_arb.sv
// Directed bench for vx_mem_arb: one fully buffered instance (b_*) and one
// unbuffered instance (c_*), both round-robin, N=4, 32-bit data.
module tb_vx_mem_arb;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  // Shared static payload: ch i -> tag, addr, data below
  logic [3:0]   p_rw;
  logic [15:0]  p_byteen;
  logic [11:0]  p_size;
  logic [127:0] p_addr;
  logic [127:0] p_data;
  logic [31:0]  p_tag;

  logic [3:0]   b_req_valid, b_req_ready;
  logic         b_mreq_valid, b_mreq_rw, b_mreq_ready;
  logic [3:0]   b_mreq_byteen;
  logic [2:0]   b_mreq_size;
  logic [31:0]  b_mreq_addr, b_mreq_data;
  logic [9:0]   b_mreq_tag;
  logic         b_mrsp_valid, b_mrsp_ready;
  logic [31:0]  b_mrsp_data;
  logic [9:0]   b_mrsp_tag;
  logic [3:0]   b_rsp_valid, b_rsp_ready;
  logic [127:0] b_rsp_data;
  logic [31:0]  b_rsp_tag;

  logic [3:0]   c_req_valid, c_req_ready;
  logic         c_mreq_valid, c_mreq_rw, c_mreq_ready;
  logic [3:0]   c_mreq_byteen;
  logic [2:0]   c_mreq_size;
  logic [31:0]  c_mreq_addr, c_mreq_data;
  logic [9:0]   c_mreq_tag;
  logic         c_mrsp_valid, c_mrsp_ready;
  logic [31:0]  c_mrsp_data;
  logic [9:0]   c_mrsp_tag;
  logic [3:0]   c_rsp_valid, c_rsp_ready;
  logic [127:0] c_rsp_data;
  logic [31:0]  c_rsp_tag;

  vx_mem_arb #(.NUM_REQS(4), .DATA_WIDTH(32), .ARB_MODE(0),
               .BUFFERED_REQ(1), .BUFFERED_RSP(1)) dut_b (
    .clk(clk), .reset(reset),
    .req_valid_in(b_req_valid), .req_rw_in(p_rw), .req_byteen_in(p_byteen),
    .req_size_in(p_size), .req_addr_in(p_addr), .req_data_in(p_data),
    .req_tag_in(p_tag), .req_ready_in(b_req_ready),
    .mem_req_valid(b_mreq_valid), .mem_req_rw(b_mreq_rw), .mem_req_byteen(b_mreq_byteen),
    .mem_req_size(b_mreq_size), .mem_req_addr(b_mreq_addr), .mem_req_data(b_mreq_data),
    .mem_req_tag(b_mreq_tag), .mem_req_ready(b_mreq_ready),
    .mem_rsp_valid(b_mrsp_valid), .mem_rsp_data(b_mrsp_data), .mem_rsp_tag(b_mrsp_tag),
    .mem_rsp_ready(b_mrsp_ready),
    .rsp_valid_out(b_rsp_valid), .rsp_data_out(b_rsp_data), .rsp_tag_out(b_rsp_tag),
    .rsp_ready_out(b_rsp_ready)
  );

  vx_mem_arb #(.NUM_REQS(4), .DATA_WIDTH(32), .ARB_MODE(0),
               .BUFFERED_REQ(0), .BUFFERED_RSP(0)) dut_c (
    .clk(clk), .reset(reset),
    .req_valid_in(c_req_valid), .req_rw_in(p_rw), .req_byteen_in(p_byteen),
    .req_size_in(p_size), .req_addr_in(p_addr), .req_data_in(p_data),
    .req_tag_in(p_tag), .req_ready_in(c_req_ready),
    .mem_req_valid(c_mreq_valid), .mem_req_rw(c_mreq_rw), .mem_req_byteen(c_mreq_byteen),
    .mem_req_size(c_mreq_size), .mem_req_addr(c_mreq_addr), .mem_req_data(c_mreq_data),
    .mem_req_tag(c_mreq_tag), .mem_req_ready(c_mreq_ready),
    .mem_rsp_valid(c_mrsp_valid), .mem_rsp_data(c_mrsp_data), .mem_rsp_tag(c_mrsp_tag),
    .mem_rsp_ready(c_mrsp_ready),
    .rsp_valid_out(c_rsp_valid), .rsp_data_out(c_rsp_data), .rsp_tag_out(c_rsp_tag),
    .rsp_ready_out(c_rsp_ready)
  );

  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Expected outgoing tags {tag_in, idx}: ch0 0x10, ch1 0x21, ch2 0x32, ch3 0x5A
  logic [9:0] exp_tag [4];

  initial begin
    exp_tag[0] = 10'h040; exp_tag[1] = 10'h085; exp_tag[2] = 10'h0CA; exp_tag[3] = 10'h16B;
    p_rw     = 4'b0101;
    p_byteen = 16'hF3C1;
    p_size   = {4{3'd6}};
    p_addr   = {32'h0000_1003, 32'h0000_1002, 32'h0000_1001, 32'h0000_1000};
    p_data   = {32'hD000_0003, 32'hD000_0002, 32'hD000_0001, 32'hD000_0000};
    p_tag    = {8'h5A, 8'h32, 8'h21, 8'h10};
    reset = 1'b0;
    b_req_valid = '0; b_mreq_ready = 1'b0; b_mrsp_valid = 1'b0; b_mrsp_data = '0;
    b_mrsp_tag = '0; b_rsp_ready = '0;
    c_req_valid = '0; c_mreq_ready = 1'b0; c_mrsp_valid = 1'b0; c_mrsp_data = '0;
    c_mrsp_tag = '0; c_rsp_ready = '0;

    // Reset state
    #2;
    chk("rst_b_mreq_valid", b_mreq_valid, 0);
    chk("rst_b_rsp_valid", b_rsp_valid, 0);
    chk("rst_c_mreq_valid", c_mreq_valid, 0);
    chk("rst_c_rsp_valid", c_rsp_valid, 0);
    tick(); tick();
    reset = 1'b1;
    tick();

    // RR with channels 1 and 3 valid, pointer at 0
    b_mreq_ready = 1'b1;
    b_req_valid  = 4'b1010;
    #1;
    chk("rr2_rdy0", b_req_ready, 4'b0010);
    chk("rr2_valid0", b_mreq_valid, 0);
    tick();
    chk("rr2_valid1", b_mreq_valid, 1);
    chk("rr2_tag1", b_mreq_tag, 10'h085);
    chk("rr2_addr1", b_mreq_addr, 32'h1001);
    chk("rr2_rdy1", b_req_ready, 4'b1000);
    tick();
    chk("rr2_tag2", b_mreq_tag, 10'h16B);
    chk("rr2_rdy2", b_req_ready, 4'b0010);
    tick();
    chk("rr2_tag3", b_mreq_tag, 10'h085);
    b_req_valid = 4'b0000;
    tick();
    chk("rr2_drain", b_mreq_valid, 0);

    // Buffered stall: pointer now 2, exactly two accepts then no ready
    b_mreq_ready = 1'b0;
    b_req_valid  = 4'b1111;
    #1;
    chk("stall_rdy0", b_req_ready, 4'b0100);
    tick();
    chk("stall_valid1", b_mreq_valid, 1);
    chk("stall_tag1", b_mreq_tag, 10'h0CA);
    chk("stall_rdy1", b_req_ready, 4'b1000);
    tick();
    chk("stall_rdy2", b_req_ready, 4'b0000);
    chk("stall_tag2", b_mreq_tag, 10'h0CA);
    tick();
    chk("stall_rdy3", b_req_ready, 4'b0000);
    chk("stall_data3", b_mreq_data, 32'hD000_0002);
    b_req_valid  = 4'b0000;
    b_mreq_ready = 1'b1;
    tick();
    chk("stall_drain_tag", b_mreq_tag, 10'h16B);
    chk("stall_drain_valid", b_mreq_valid, 1);
    tick();
    chk("stall_empty", b_mreq_valid, 0);

    // Reset mid-burst with two requests and one response buffered (pointer ends at 3)
    b_mreq_ready = 1'b0;
    b_req_valid  = 4'b0110;
    b_mrsp_valid = 1'b1;
    b_mrsp_tag   = 10'h1DC;
    b_mrsp_data  = 32'h7777_0000;
    b_rsp_ready  = 4'b0000;
    #1;
    chk("mr_rdy0", b_req_ready, 4'b0010);
    chk("mr_mrsp_ready", b_mrsp_ready, 1);
    tick();
    b_mrsp_valid = 1'b0;
    #1;
    chk("mr_rdy1", b_req_ready, 4'b0100);
    chk("mr_rsp_valid", b_rsp_valid, 4'b0001);
    tick();
    chk("mr_full_rdy", b_req_ready, 4'b0000);
    chk("mr_full_valid", b_mreq_valid, 1);
    reset = 1'b0;
    #1;
    chk("mr_async_mreq", b_mreq_valid, 0);
    chk("mr_async_rsp", b_rsp_valid, 0);
    chk("mr_async_rdy", b_req_ready, 0);
    b_req_valid = 4'b0000;
    tick();
    reset = 1'b1;
    b_req_valid  = 4'b1111;
    b_mreq_ready = 1'b1;
    #1;
    chk("post_rst_grant", b_req_ready, 4'b0001);
    chk("post_rst_empty", b_mreq_valid, 0);

    // RR all channels valid: grants 0,1,2,3,0,1,2 with one accept per cycle
    for (int k = 1; k <= 6; k++) begin
      tick();
      chk("rr4_rdy", b_req_ready, 4'b0001 << (k % 4));
      chk("rr4_valid", b_mreq_valid, 1);
      chk("rr4_tag", b_mreq_tag, exp_tag[(k - 1) % 4]);
    end
    b_req_valid = 4'b0000;
    tick();
    chk("rr4_drain", b_mreq_valid, 0);

    // Buffered responses: ch3 stalled, ch0 flows past it
    b_rsp_ready  = 4'b0111;
    b_mrsp_valid = 1'b1;
    b_mrsp_tag   = 10'h16B;
    b_mrsp_data  = 32'hAAAA_0003;
    #1;
    chk("rsp_ready0", b_mrsp_ready, 1);
    tick();
    b_mrsp_tag  = 10'h040;
    b_mrsp_data = 32'hBBBB_0000;
    #1;
    chk("rsp_ready1", b_mrsp_ready, 1);
    chk("rsp_valid1", b_rsp_valid, 4'b1000);
    chk("rsp_tag_ch3", b_rsp_tag[31:24], 8'h5A);
    chk("rsp_data_ch3", b_rsp_data[127:96], 32'hAAAA_0003);
    tick();
    b_mrsp_valid = 1'b0;
    #1;
    chk("rsp_valid2", b_rsp_valid, 4'b1001);
    chk("rsp_tag_ch0", b_rsp_tag[7:0], 8'h10);
    chk("rsp_data_ch0", b_rsp_data[31:0], 32'hBBBB_0000);
    tick();
    chk("rsp_valid3", b_rsp_valid, 4'b1000);
    b_mrsp_valid = 1'b1;
    b_mrsp_tag   = 10'h16B;
    b_mrsp_data  = 32'hAAAA_0013;
    #1;
    chk("rsp_ready_ch3_one", b_mrsp_ready, 1);
    tick();
    chk("rsp_ready_ch3_full", b_mrsp_ready, 0);
    b_mrsp_tag  = 10'h085;
    b_mrsp_data = 32'hCCCC_0001;
    #1;
    chk("rsp_ready_ch1", b_mrsp_ready, 1);
    tick();
    b_mrsp_valid = 1'b0;
    #1;
    chk("rsp_valid4", b_rsp_valid, 4'b1010);
    chk("rsp_tag_ch1", b_rsp_tag[15:8], 8'h21);
    b_rsp_ready = 4'b1111;
    #1;
    chk("rsp_ch3_first", b_rsp_data[127:96], 32'hAAAA_0003);
    tick();
    chk("rsp_valid5", b_rsp_valid, 4'b1000);
    chk("rsp_ch3_second", b_rsp_data[127:96], 32'hAAAA_0013);
    tick();
    chk("rsp_valid6", b_rsp_valid, 4'b0000);

    // Unbuffered grant lock: ch2 stalls, ch0 arrives mid-stall (pointer at 0)
    c_mreq_ready = 1'b0;
    c_req_valid  = 4'b0100;
    #1;
    chk("lock_valid0", c_mreq_valid, 1);
    chk("lock_tag0", c_mreq_tag, 10'h0CA);
    chk("lock_rdy0", c_req_ready, 4'b0000);
    tick();
    c_req_valid = 4'b0101;
    #1;
    chk("lock_tag1", c_mreq_tag, 10'h0CA);
    chk("lock_addr1", c_mreq_addr, 32'h1002);
    for (int s = 0; s < 3; s++) begin
      tick();
      chk("lock_tag_hold", c_mreq_tag, 10'h0CA);
      chk("lock_data_hold", c_mreq_data, 32'hD000_0002);
    end
    c_mreq_ready = 1'b1;
    #1;
    chk("lock_rdy_rel", c_req_ready, 4'b0100);
    chk("lock_tag_rel", c_mreq_tag, 10'h0CA);
    tick();
    c_req_valid = 4'b0001;
    #1;
    chk("lock_next_tag", c_mreq_tag, 10'h040);
    chk("lock_next_rdy", c_req_ready, 4'b0001);
    tick();
    c_req_valid = 4'b0000;
    #1;
    chk("lock_idle", c_mreq_valid, 0);

    // Unbuffered response routing
    c_rsp_ready  = 4'b0010;
    c_mrsp_valid = 1'b1;
    c_mrsp_tag   = 10'h085;
    c_mrsp_data  = 32'h1234_5678;
    #1;
    chk("ursp_valid", c_rsp_valid, 4'b0010);
    chk("ursp_ready", c_mrsp_ready, 1);
    chk("ursp_tag", c_rsp_tag[15:8], 8'h21);
    chk("ursp_data", c_rsp_data[63:32], 32'h1234_5678);
    c_rsp_ready = 4'b0000;
    #1;
    chk("ursp_stall", c_mrsp_ready, 0);
    c_mrsp_valid = 1'b0;
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
